// File: rtl/relu_maxpool_pkg.sv
// Shared definitions for the ReLU + requantise + 2x2 max-pool stage:
// default widths, FSM state encoding and the per-pixel arithmetic helpers.
package relu_maxpool_pkg;

    localparam int unsigned BIT_DEPTH_DEF = 8;
    localparam int unsigned ACC_W_DEF     = 20;

    // Frame FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Index width that never collapses to zero bits
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // ReLU, arithmetic right shift, then clamp to the unsigned output range
    function automatic logic [31:0] quantise(input logic signed [63:0] acc,
                                             input int unsigned       shift,
                                             input int unsigned       bit_depth);
        logic signed [63:0] shifted;
        logic [63:0]        max_val;
        shifted = acc >>> shift;
        max_val = (64'd1 << bit_depth) - 64'd1;
        if (acc[63]) begin
            return '0;
        end
        if ($unsigned(shifted) > max_val) begin
            return max_val[31:0];
        end
        return shifted[31:0];
    endfunction

    function automatic logic [31:0] max2(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_rowbuf.sv
// Half-width row buffer holding the max of each horizontal pixel pair of an
// even row until the matching odd row arrives. Contents need no reset.
module pool_rowbuf #(
    parameter int unsigned DEPTH = 13,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Single write port; the read side is asynchronous on the same address
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/relu_maxpool.sv
// ReLU + requantisation of the raw convolution stream followed by a 2x2
// stride-2 max-pool. Pixels arrive in raster order, one per accepted beat.
module relu_maxpool
    import relu_maxpool_pkg::*;
#(
    parameter int unsigned BIT_DEPTH = BIT_DEPTH_DEF,
    parameter int unsigned ACC_W     = ACC_W_DEF,
    parameter int unsigned IN_COLS   = 26,
    parameter int unsigned IN_ROWS   = 26,
    parameter int unsigned SHIFT     = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              in_valid,
    input  logic signed [ACC_W-1:0]           in_data,
    output logic                              out_valid,
    output logic [BIT_DEPTH-1:0]              out_data,
    output logic [idx_w(IN_COLS/2)-1:0]       out_col,
    output logic [idx_w(IN_ROWS/2)-1:0]       out_row,
    output logic                              busy,
    output logic                              done
);

    localparam int unsigned COL_W    = idx_w(IN_COLS);
    localparam int unsigned ROW_W    = idx_w(IN_ROWS);
    localparam int unsigned PC_W     = idx_w(IN_COLS/2);
    localparam int unsigned PR_W     = idx_w(IN_ROWS/2);
    localparam int unsigned POOL_COLS = IN_COLS / 2;
    localparam bit          ROWS_ODD = (IN_ROWS % 2) == 1;

    logic [1:0]           state;
    logic [COL_W-1:0]     c;
    logic [ROW_W-1:0]     r;
    logic [BIT_DEPTH-1:0] q;
    logic [BIT_DEPTH-1:0] hold;
    logic [BIT_DEPTH-1:0] pair_max;
    logic [BIT_DEPTH-1:0] pool_max;
    logic [BIT_DEPTH-1:0] rb_rdata;
    logic [PC_W-1:0]      p;
    logic                 accept;
    logic                 last_col;
    logic                 last_row;
    logic                 rb_we;
    logic                 pool_fire;

    // Per-beat datapath: quantised pixel, pooling address and write/fire strobes
    always_comb begin
        accept    = (state == ST_RUN) && in_valid;
        last_col  = (c == COL_W'(IN_COLS - 1));
        last_row  = (r == ROW_W'(IN_ROWS - 1));
        q         = BIT_DEPTH'(quantise(64'(in_data), SHIFT, BIT_DEPTH));
        p         = PC_W'(c >> 1);
        pair_max  = BIT_DEPTH'(max2(32'(hold), 32'(q)));
        pool_max  = BIT_DEPTH'(max2(32'(pair_max), 32'(rb_rdata)));
        // An odd last row (if any) is never pooled, so it must not touch rowbuf
        rb_we     = accept && c[0] && !r[0] && !(ROWS_ODD && last_row);
        pool_fire = accept && c[0] && r[0];
    end

    pool_rowbuf #(
        .DEPTH (POOL_COLS),
        .WIDTH (BIT_DEPTH),
        .AW    (PC_W)
    ) u_rowbuf (
        .clk   (clk),
        .we    (rb_we),
        .addr  (p),
        .wdata (pair_max),
        .rdata (rb_rdata)
    );

    // Frame FSM and raster counters; counters move only on accepted beats
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            c     <= '0;
            r     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        c     <= '0;
                        r     <= '0;
                    end
                end
                ST_RUN: begin
                    if (in_valid) begin
                        if (last_col) begin
                            c <= '0;
                            if (last_row) begin
                                r     <= '0;
                                state <= ST_DONE;
                            end else begin
                                r <= r + ROW_W'(1);
                            end
                        end else begin
                            c <= c + COL_W'(1);
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Left pixel of each horizontal pair waits here for its partner
    always_ff @(posedge clk) begin
        if (accept && !c[0]) begin
            hold <= q;
        end
    end

    // Registered pooled output, one-cycle valid pulse per completed window
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_col   <= '0;
            out_row   <= '0;
        end else begin
            out_valid <= pool_fire;
            if (pool_fire) begin
                out_data <= pool_max;
                out_col  <= p;
                out_row  <= PR_W'(r >> 1);
            end
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_relu_maxpool.sv
// Directed bench: a 4x4 instance for the main pooling behaviour and a 5x5
// instance for odd-dimension handling and ignored start/in_valid.
module tb_relu_maxpool;

    logic clk;

    logic              a_rst, a_start, a_in_valid;
    logic signed [19:0] a_in_data;
    logic              a_out_valid, a_busy, a_done;
    logic [7:0]        a_out_data;
    logic [0:0]        a_out_col, a_out_row;

    logic              b_rst, b_start, b_in_valid;
    logic signed [19:0] b_in_data;
    logic              b_out_valid, b_busy, b_done;
    logic [7:0]        b_out_data;
    logic [0:0]        b_out_col, b_out_row;

    int n_assert = 0;
    int n_fail   = 0;

    int f1[16];
    int f2[16];
    int f3[16];
    int e1[4];
    int e2[4];
    int e3[4];
    int eb[4];

    relu_maxpool #(
        .BIT_DEPTH (8),
        .ACC_W     (20),
        .IN_COLS   (4),
        .IN_ROWS   (4),
        .SHIFT     (4)
    ) dut_a (
        .clk       (clk),
        .rst       (a_rst),
        .start     (a_start),
        .in_valid  (a_in_valid),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_data  (a_out_data),
        .out_col   (a_out_col),
        .out_row   (a_out_row),
        .busy      (a_busy),
        .done      (a_done)
    );

    relu_maxpool #(
        .BIT_DEPTH (8),
        .ACC_W     (20),
        .IN_COLS   (5),
        .IN_ROWS   (5),
        .SHIFT     (4)
    ) dut_b (
        .clk       (clk),
        .rst       (b_rst),
        .start     (b_start),
        .in_valid  (b_in_valid),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .out_col   (b_out_col),
        .out_row   (b_out_row),
        .busy      (b_busy),
        .done      (b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic rst_v, input logic st,
                         input logic iv, input int d);
        if (sel) begin
            b_rst = rst_v; b_start = st; b_in_valid = iv; b_in_data = 20'(d);
        end else begin
            a_rst = rst_v; a_start = st; a_in_valid = iv; a_in_data = 20'(d);
        end
    endtask

    task automatic check_out(input bit sel, input string tag, input bit ov,
                             input int od, input int oc, input int orow,
                             input bit dn, input bit bs);
        logic       ovo, dno, bso;
        logic [7:0] odo;
        logic       oco, oro;
        ovo = sel ? b_out_valid : a_out_valid;
        odo = sel ? b_out_data  : a_out_data;
        oco = sel ? b_out_col[0] : a_out_col[0];
        oro = sel ? b_out_row[0] : a_out_row[0];
        dno = sel ? b_done : a_done;
        bso = sel ? b_busy : a_busy;
        chk({tag, ".valid"}, ovo, ov);
        if (ov) begin
            chk({tag, ".data"}, odo, od);
            chk({tag, ".col"},  oco, oc);
            chk({tag, ".row"},  oro, orow);
        end
        chk({tag, ".done"}, dno, dn);
        chk({tag, ".busy"}, bso, bs);
    endtask

    // One clock: drive at negedge, check registered outputs just after posedge
    task automatic cycle(input bit sel, input logic rst_v, input logic st,
                         input logic iv, input int d, input string tag,
                         input bit ov, input int od, input int oc, input int orow,
                         input bit dn, input bit bs);
        @(negedge clk);
        drive(sel, rst_v, st, iv, d);
        @(posedge clk);
        #1;
        check_out(sel, tag, ov, od, oc, orow, dn, bs);
    endtask

    task automatic frame_a(input int fid, input int v[16], input int gap, input int e[4]);
        int k;
        int r;
        int c;
        bit ov;
        k = 0;
        cycle(0, 0, 1, 0, 0, $sformatf("a.f%0d.start", fid), 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            for (int g = 0; g < gap; g++) begin
                cycle(0, 0, 0, 0, 0, $sformatf("a.f%0d.gap%0d", fid, i), 0, 0, 0, 0, 0, 1);
            end
            r  = i / 4;
            c  = i % 4;
            ov = (r % 2 == 1) && (c % 2 == 1);
            cycle(0, 0, 0, 1, v[i], $sformatf("a.f%0d.b%0d", fid, i),
                  ov, ov ? e[k] : 0, c / 2, r / 2, i == 15, 1);
            if (ov) k++;
        end
        cycle(0, 0, 0, 0, 0, $sformatf("a.f%0d.idle", fid), 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int r;
        int c;
        int k;
        bit ov;

        f1 = '{default: 256};
        e1 = '{16, 16, 16, 16};
        // 800 sits in a different quadrant of each window
        f2 = '{160, 320, 800, 160,
               48,  800, 320, 48,
               160, 800, 160, 320,
               48,  320, 800, 48};
        e2 = '{50, 50, 50, 50};
        f3 = '{-500,    -500,    'h7FFFF, 0,
               -500,    -500,    0,       0,
               'h80000, 'h80000, 272,     1000,
               'h80000, 33,      15,      64};
        e3 = '{0, 255, 2, 62};
        eb = '{51, 53, 31, 33};

        a_rst = 1; a_start = 0; a_in_valid = 0; a_in_data = '0;
        b_rst = 1; b_start = 0; b_in_valid = 0; b_in_data = '0;
        repeat (2) @(posedge clk);

        // Reset state of both instances
        cycle(0, 1, 0, 0, 0, "a.reset", 0, 0, 0, 0, 0, 0);
        chk("a.reset.data", a_out_data, 0);
        chk("a.reset.col",  a_out_col, 0);
        chk("a.reset.row",  a_out_row, 0);
        cycle(1, 1, 0, 0, 0, "b.reset", 0, 0, 0, 0, 0, 0);
        chk("b.reset.data", b_out_data, 0);
        chk("b.reset.col",  b_out_col, 0);
        chk("b.reset.row",  b_out_row, 0);
        cycle(0, 0, 0, 0, 0, "a.post_reset", 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, "b.post_reset", 0, 0, 0, 0, 0, 0);

        frame_a(1, f1, 0, e1);
        frame_a(2, f2, 0, e2);
        frame_a(3, f3, 0, e3);
        frame_a(4, f3, 2, e3);

        // Reset after 6 accepted beats (the 6th completes window (0,0))
        cycle(0, 0, 1, 0, 0, "a.abort.start", 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 0, 1, f2[i], $sformatf("a.abort.b%0d", i),
                  i == 5, 50, 0, 0, 0, 1);
        end
        cycle(0, 1, 0, 1, f2[6], "a.abort.rst", 0, 0, 0, 0, 0, 0);
        chk("a.abort.rst.data", a_out_data, 0);
        cycle(0, 0, 0, 0, 0, "a.abort.idle", 0, 0, 0, 0, 0, 0);
        frame_a(5, f3, 0, e3);

        // 5x5: in_valid while idle is ignored
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 1, 3200, $sformatf("b.idle_iv%0d", i), 0, 0, 0, 0, 0, 0);
        end
        cycle(1, 0, 1, 0, 0, "b.start", 0, 0, 0, 0, 0, 1);
        k = 0;
        for (int i = 0; i < 25; i++) begin
            r  = i / 5;
            c  = i % 5;
            ov = (r % 2 == 1) && (c % 2 == 1) && (r < 4) && (c < 4);
            // start pulsed mid-frame at beat 10 must not restart the counters
            cycle(1, 0, i == 10, 1,
                  (r < 4 && c < 4) ? 16 * (10 * (5 - r) + c) : 3200,
                  $sformatf("b.b%0d", i), ov, ov ? eb[k] : 0, c / 2, r / 2,
                  i == 24, 1);
            if (ov) k++;
        end
        cycle(1, 0, 0, 0, 0, "b.idle", 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, "b.idle2", 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
